// File: rtl/kronos_lsu.sv
// Kronos load-store unit: single-outstanding data-bus master with lane masking, load extension,
// misalignment and timeout errors. Define KRONOS_LSU_MISALIGN_EN to split misaligned accesses.
module kronos_lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 0,
    parameter int unsigned TIMEOUT_W      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lsu_vld,
    output logic        lsu_rdy,
    input  logic [31:0] lsu_addr,
    input  logic [31:0] lsu_wdata,
    input  logic [1:0]  lsu_size,
    input  logic        lsu_unsigned,
    input  logic        lsu_store,
    input  logic [4:0]  lsu_rd,
    output logic        lsu_done,
    output logic        lsu_err,
    output logic [1:0]  lsu_err_code,
    output logic [31:0] lsu_err_addr,
    output logic [31:0] data_addr,
    input  logic [31:0] data_rd_data,
    output logic [31:0] data_wr_data,
    output logic [3:0]  data_mask,
    output logic        data_wr_en,
    output logic        data_req,
    input  logic        data_ack,
    output logic [31:0] regwr_data,
    output logic [4:0]  regwr_sel,
    output logic        regwr_en
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
`ifdef KRONOS_LSU_MISALIGN_EN
        StReq2 = 2'd3,
`endif
        StResp = 2'd2
    } state_e;

    localparam bit TimeoutEn = (TIMEOUT_CYCLES > 0);
    localparam logic [TIMEOUT_W-1:0] TimeoutLast =
        TIMEOUT_W'(TimeoutEn ? TIMEOUT_CYCLES - 1 : 0);

    state_e                state_q, state_d;
    logic [31:0]           addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [1:0]            size_q, size_d;
    logic                  unsigned_q, unsigned_d;
    logic                  store_q, store_d;
    logic [4:0]            rd_q, rd_d;
    logic                  err_q, err_d;
    logic [1:0]            err_code_q, err_code_d;
    logic [31:0]           result_q, result_d;
    logic [TIMEOUT_W-1:0]  tcnt_q, tcnt_d;
`ifdef KRONOS_LSU_MISALIGN_EN
    logic [31:0]           lo_q, lo_d;
    logic [3:0]            mask_hi;
    logic                  cross;
`endif

    logic [1:0]  off;
    logic [3:0]  lane_base;
    logic [3:0]  mask_lo;
    logic [31:0] wr_repl;
    logic [31:0] wr_rot;
    logic        mis_in;
    logic        timeout_hit;

    function automatic logic [31:0] load_ext(input logic [63:0] pair, input logic [1:0] sh,
                                             input logic [1:0] size, input logic uns);
        logic [31:0] w;
        w = 32'(pair >> {sh, 3'b000});
        case (size)
            2'd0:    load_ext = {{24{~uns & w[7]}}, w[7:0]};
            2'd1:    load_ext = {{16{~uns & w[15]}}, w[15:0]};
            default: load_ext = w;
        endcase
    endfunction

    assign off         = addr_q[1:0];
    assign lane_base   = (size_q == 2'd0) ? 4'b0001 : (size_q == 2'd1) ? 4'b0011 : 4'b1111;
    assign mask_lo     = lane_base << off;
    assign wr_repl     = (size_q == 2'd0) ? {4{wdata_q[7:0]}} :
                         (size_q == 2'd1) ? {2{wdata_q[15:0]}} : wdata_q;
    // Rotation lines each byte up with its lane; a no-op for aligned accesses.
    assign wr_rot      = (wr_repl << {off, 3'b000}) | (wr_repl >> (6'd32 - {1'b0, off, 3'b000}));
    assign mis_in      = ((lsu_size == 2'd1) && lsu_addr[0]) ||
                         (lsu_size[1] && (lsu_addr[1:0] != 2'b00));
    assign timeout_hit = TimeoutEn && (tcnt_q == TimeoutLast);
`ifdef KRONOS_LSU_MISALIGN_EN
    assign mask_hi     = lane_base >> (3'd4 - {1'b0, off});
    assign cross       = |mask_hi;
`endif

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        size_d     = size_q;
        unsigned_d = unsigned_q;
        store_d    = store_q;
        rd_d       = rd_q;
        err_d      = err_q;
        err_code_d = err_code_q;
        result_d   = result_q;
        tcnt_d     = tcnt_q;
`ifdef KRONOS_LSU_MISALIGN_EN
        lo_d       = lo_q;
`endif
        case (state_q)
            StIdle: begin
                if (lsu_vld) begin
                    addr_d     = lsu_addr;
                    wdata_d    = lsu_wdata;
                    size_d     = lsu_size;
                    unsigned_d = lsu_unsigned;
                    store_d    = lsu_store;
                    rd_d       = lsu_rd;
                    err_d      = 1'b0;
                    err_code_d = 2'd0;
                    tcnt_d     = '0;
`ifdef KRONOS_LSU_MISALIGN_EN
                    state_d    = StReq;
`else
                    if (mis_in) begin
                        err_d      = 1'b1;
                        err_code_d = lsu_store ? 2'd2 : 2'd1;
                        state_d    = StResp;
                    end else begin
                        state_d    = StReq;
                    end
`endif
                end
            end
            StReq: begin
                if (data_ack) begin
`ifdef KRONOS_LSU_MISALIGN_EN
                    if (cross) begin
                        lo_d    = data_rd_data;
                        tcnt_d  = '0;
                        state_d = StReq2;
                    end else
`endif
                    begin
                        if (!store_q) begin
                            result_d = load_ext({32'b0, data_rd_data}, off, size_q, unsigned_q);
                        end
                        state_d = StResp;
                    end
                end else if (timeout_hit) begin
                    err_d      = 1'b1;
                    err_code_d = 2'd3;
                    state_d    = StResp;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
`ifdef KRONOS_LSU_MISALIGN_EN
            StReq2: begin
                if (data_ack) begin
                    if (!store_q) begin
                        result_d = load_ext({data_rd_data, lo_q}, off, size_q, unsigned_q);
                    end
                    state_d = StResp;
                end else if (timeout_hit) begin
                    err_d      = 1'b1;
                    err_code_d = 2'd3;
                    state_d    = StResp;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
`endif
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        data_req     = 1'b0;
        data_addr    = '0;
        data_mask    = '0;
        data_wr_data = '0;
        data_wr_en   = 1'b0;
        case (state_q)
            StReq: begin
                data_req     = 1'b1;
                data_addr    = {addr_q[31:2], 2'b00};
                data_mask    = mask_lo;
                data_wr_data = wr_rot;
                data_wr_en   = store_q;
            end
`ifdef KRONOS_LSU_MISALIGN_EN
            StReq2: begin
                data_req     = 1'b1;
                data_addr    = {addr_q[31:2] + 30'd1, 2'b00};
                data_mask    = mask_hi;
                data_wr_data = wr_rot;
                data_wr_en   = store_q;
            end
`endif
            default: ;
        endcase
    end

    assign lsu_rdy      = (state_q == StIdle);
    assign lsu_done     = (state_q == StResp);
    assign lsu_err      = lsu_done & err_q;
    assign lsu_err_code = lsu_err ? err_code_q : 2'd0;
    assign lsu_err_addr = lsu_err ? addr_q : 32'd0;
    assign regwr_en     = lsu_done & ~err_q & ~store_q & (rd_q != 5'd0);
    assign regwr_data   = result_q;
    assign regwr_sel    = rd_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            wdata_q    <= '0;
            size_q     <= '0;
            unsigned_q <= 1'b0;
            store_q    <= 1'b0;
            rd_q       <= '0;
            err_q      <= 1'b0;
            err_code_q <= '0;
            result_q   <= '0;
            tcnt_q     <= '0;
`ifdef KRONOS_LSU_MISALIGN_EN
            lo_q       <= '0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            size_q     <= size_d;
            unsigned_q <= unsigned_d;
            store_q    <= store_d;
            rd_q       <= rd_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            result_q   <= result_d;
            tcnt_q     <= tcnt_d;
`ifdef KRONOS_LSU_MISALIGN_EN
            lo_q       <= lo_d;
`endif
        end
    end

endmodule

// File: tb/tb_kronos_lsu.sv
// Self-checking bench for kronos_lsu: directed and random ops against a byte-addressed memory
// model; honours KRONOS_LSU_MISALIGN_EN when the build defines it.
module tb_kronos_lsu;

    localparam int unsigned TO = 4;
`ifdef KRONOS_LSU_MISALIGN_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        lsu_vld;
    logic        lsu_rdy;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic [1:0]  lsu_size;
    logic        lsu_unsigned;
    logic        lsu_store;
    logic [4:0]  lsu_rd;
    logic        lsu_done;
    logic        lsu_err;
    logic [1:0]  lsu_err_code;
    logic [31:0] lsu_err_addr;
    logic [31:0] data_addr;
    logic [31:0] data_rd_data;
    logic [31:0] data_wr_data;
    logic [3:0]  data_mask;
    logic        data_wr_en;
    logic        data_req;
    logic        data_ack;
    logic [31:0] regwr_data;
    logic [4:0]  regwr_sel;
    logic        regwr_en;

    kronos_lsu #(
        .TIMEOUT_CYCLES(TO),
        .TIMEOUT_W     (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .lsu_vld      (lsu_vld),
        .lsu_rdy      (lsu_rdy),
        .lsu_addr     (lsu_addr),
        .lsu_wdata    (lsu_wdata),
        .lsu_size     (lsu_size),
        .lsu_unsigned (lsu_unsigned),
        .lsu_store    (lsu_store),
        .lsu_rd       (lsu_rd),
        .lsu_done     (lsu_done),
        .lsu_err      (lsu_err),
        .lsu_err_code (lsu_err_code),
        .lsu_err_addr (lsu_err_addr),
        .data_addr    (data_addr),
        .data_rd_data (data_rd_data),
        .data_wr_data (data_wr_data),
        .data_mask    (data_mask),
        .data_wr_en   (data_wr_en),
        .data_req     (data_req),
        .data_ack     (data_ack),
        .regwr_data   (regwr_data),
        .regwr_sel    (regwr_sel),
        .regwr_en     (regwr_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0] mem [logic [31:0]];

    function automatic logic [7:0] byte_at(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a[7:0] ^ 8'hA5;
    endfunction

    function automatic logic [31:0] bus_word(input logic [31:0] base);
        return {byte_at(base + 3), byte_at(base + 2), byte_at(base + 1), byte_at(base)};
    endfunction

    task automatic set_word(input logic [31:0] a, input logic [31:0] w);
        for (int i = 0; i < 4; i++) mem[a + i] = w[8*i +: 8];
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One op end to end: bench plays the bus from its memory model, checks every bus cycle
    // and the retirement against values derived from byte-level arithmetic.
    task automatic run_op(input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [1:0] size, input logic uns, input logic store,
                          input logic [4:0] rd, input int delay, input bit to_exp,
                          output logic [31:0] o_rdata, output logic [31:0] o_wdata,
                          output logic [3:0] o_mask);
        int          n, cyc, txn, ntxn, req_cnt, exp_done, total_req;
        bit          mis, exp_err, done_seen;
        logic [1:0]  exp_code;
        logic [31:0] exp_val, base, d;
        logic [3:0]  exp_mask;
        logic [7:0]  exp_byte;

        n   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        mis = (n == 2 && addr[0]) || (n == 4 && addr[1:0] != 2'b00);
        exp_err  = 1'b0;
        exp_code = 2'd0;
        if (mis && !MIS_EN) begin
            exp_err  = 1'b1;
            exp_code = store ? 2'd2 : 2'd1;
        end else if (to_exp) begin
            exp_err  = 1'b1;
            exp_code = 2'd3;
        end
        ntxn = (mis && !MIS_EN) ? 0 : ((int'(addr[1:0]) + n > 4) ? 2 : 1);
        if (exp_code == 2'd3) exp_done = 1 + TO;
        else if (ntxn == 0)   exp_done = 1;
        else                  exp_done = 1 + ntxn * (delay + 1);

        exp_val = '0;
        for (int i = 0; i < n; i++) exp_val[8*i +: 8] = byte_at(addr + i);
        if (!uns && n < 4 && exp_val[8*n-1]) begin
            for (int i = n; i < 4; i++) exp_val[8*i +: 8] = 8'hFF;
        end

        check("rdy_idle", 32'(lsu_rdy), 32'd1);
        lsu_vld      = 1'b1;
        lsu_addr     = addr;
        lsu_wdata    = wdata;
        lsu_size     = size;
        lsu_unsigned = uns;
        lsu_store    = store;
        lsu_rd       = rd;
        @(posedge clk); #1;
        lsu_vld   = 1'b0;
        lsu_addr  = $urandom;
        lsu_wdata = $urandom;
        lsu_rd    = 5'($urandom);

        cyc = 1; txn = 0; req_cnt = 0; total_req = 0; done_seen = 1'b0;
        o_rdata = '0; o_wdata = '0; o_mask = '0;
        while (cyc <= 40 && !done_seen) begin
            data_ack     = 1'b0;
            data_rd_data = $urandom;
            check("rdy_busy", 32'(lsu_rdy), 32'd0);
            if (lsu_done) begin
                done_seen = 1'b1;
                check("done_cycle", cyc, exp_done);
                check("err", 32'(lsu_err), 32'(exp_err));
                check("err_code", 32'(lsu_err_code), 32'(exp_code));
                check("err_addr", lsu_err_addr, exp_err ? addr : 32'd0);
                check("req_cycles", total_req, to_exp ? TO : ntxn * (delay + 1));
                check("regwr_en", 32'(regwr_en), 32'(!store && !exp_err && rd != 5'd0));
                if (!store && !exp_err) begin
                    check("regwr_data", regwr_data, exp_val);
                    check("regwr_sel", 32'(regwr_sel), 32'(rd));
                end
                o_rdata = regwr_data;
                if (to_exp) data_ack = 1'b1;  // late ack after abort
            end else begin
                check("no_early_wb", 32'(regwr_en), 32'd0);
                if (data_req) begin
                    total_req++;
                    req_cnt++;
                    base = {addr[31:2], 2'b00} + 32'(4 * txn);
                    for (int i = 0; i < 4; i++) begin
                        d = base + 32'(i) - addr;
                        exp_mask[i] = (d < 32'(n));
                    end
                    check("bus_addr", data_addr, base);
                    check("bus_mask", 32'(data_mask), 32'(exp_mask));
                    check("bus_wr_en", 32'(data_wr_en), 32'(store));
                    if (store) begin
                        for (int i = 0; i < 4; i++) begin
                            d = base + 32'(i) - addr;
                            if (d < 32'(n)) begin
                                exp_byte = 8'(wdata >> (8 * d));
                                check("bus_lane", 32'(data_wr_data[8*i +: 8]), 32'(exp_byte));
                            end
                        end
                    end
                    if (txn == 0 && req_cnt == 1) begin
                        o_wdata = data_wr_data;
                        o_mask  = data_mask;
                    end
                    if (!to_exp && req_cnt == delay + 1) begin
                        data_ack     = 1'b1;
                        data_rd_data = bus_word(base);
                        txn++;
                        req_cnt = 0;
                    end
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        data_ack = 1'b0;
        if (!done_seen) check("done_missing", 32'd0, 32'd1);
        check("rdy_after", 32'(lsu_rdy), 32'd1);
        check("done_after", 32'(lsu_done), 32'd0);
        if (store && !exp_err) begin
            for (int i = 0; i < n; i++) mem[addr + i] = wdata[8*i +: 8];
        end
    endtask

    initial begin
        logic [31:0] r, w;
        logic [3:0]  m;
        rst = 1'b1; lsu_vld = 1'b0; lsu_addr = '0; lsu_wdata = '0; lsu_size = '0;
        lsu_unsigned = 1'b0; lsu_store = 1'b0; lsu_rd = '0; data_ack = 1'b0; data_rd_data = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        check("rst_rdy", 32'(lsu_rdy), 32'd1);
        check("rst_req", 32'(data_req), 32'd0);
        check("rst_addr", data_addr, 32'd0);
        check("rst_mask", 32'(data_mask), 32'd0);
        check("rst_wr", {data_wr_data[30:0], data_wr_en}, 32'd0);
        check("rst_done", {29'd0, lsu_done, lsu_err, regwr_en}, 32'd0);
        check("rst_err_code", 32'(lsu_err_code), 32'd0);
        check("rst_err_addr", lsu_err_addr, 32'd0);
        check("rst_regwr_data", regwr_data, 32'd0);
        check("rst_regwr_sel", 32'(regwr_sel), 32'd0);

        set_word(32'h100, 32'hDEADBEEF);
        run_op(32'h100, 32'd0, 2'd2, 1'b0, 1'b0, 5'd5, 2, 1'b0, r, w, m);
        check("lw_data", r, 32'hDEADBEEF);
        check("lw_mask", 32'(m), 32'hF);

        set_word(32'h200, 32'h80112233);
        run_op(32'h203, 32'd0, 2'd0, 1'b0, 1'b0, 5'd6, 0, 1'b0, r, w, m);
        check("lb_data", r, 32'hFFFFFF80);
        check("lb_mask", 32'(m), 32'h8);
        run_op(32'h203, 32'd0, 2'd0, 1'b1, 1'b0, 5'd6, 1, 1'b0, r, w, m);
        check("lbu_data", r, 32'h00000080);
        check("lbu_mask", 32'(m), 32'h8);

        run_op(32'h302, 32'h0000ABCD, 2'd1, 1'b0, 1'b1, 5'd7, 1, 1'b0, r, w, m);
        check("sh_wdata", w, 32'hABCDABCD);
        check("sh_mask", 32'(m), 32'hC);
        run_op(32'h300, 32'd0, 2'd2, 1'b0, 1'b0, 5'd8, 0, 1'b0, r, w, m);

        set_word(32'h100, 32'h44332211);
        set_word(32'h104, 32'h88776655);
        run_op(32'h101, 32'd0, 2'd2, 1'b0, 1'b0, 5'd9, 1, 1'b0, r, w, m);
`ifdef KRONOS_LSU_MISALIGN_EN
        check("lw_mis_data", r, 32'h55443322);
`endif
        run_op(32'h103, 32'h00001357, 2'd1, 1'b0, 1'b1, 5'd0, 0, 1'b0, r, w, m);
        run_op(32'h102, 32'd0, 2'd2, 1'b1, 1'b0, 5'd10, 2, 1'b0, r, w, m);

        run_op(32'h400, 32'd0, 2'd2, 1'b0, 1'b0, 5'd3, 0, 1'b1, r, w, m);
        run_op(32'h400, 32'd0, 2'd2, 1'b0, 1'b0, 5'd3, 3, 1'b0, r, w, m);
        run_op(32'h404, 32'd0, 2'd0, 1'b0, 1'b0, 5'd0, 0, 1'b0, r, w, m);

        // Reset while a request is outstanding
        lsu_vld = 1'b1; lsu_addr = 32'h500; lsu_size = 2'd2; lsu_store = 1'b0; lsu_rd = 5'd4;
        @(posedge clk); #1;
        lsu_vld = 1'b0;
        check("mid_req", 32'(data_req), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_rst_req", 32'(data_req), 32'd0);
        check("mid_rst_rdy", 32'(lsu_rdy), 32'd1);
        for (int i = 0; i < 4; i++) begin
            data_ack = 1'b1;  // stray acks while idle
            check("mid_rst_quiet", {29'd0, lsu_done, regwr_en, data_req}, 32'd0);
            @(posedge clk); #1;
        end
        data_ack = 1'b0;

        for (int k = 0; k < 60; k++) begin
            run_op(32'h1000 + 32'($urandom_range(0, 63)), $urandom, 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 31)), int'($urandom_range(0, 3)), 1'b0, r, w, m);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed hang expected $finish");
        $fatal(1);
    end

endmodule
